// File: rtl/instr_seq_ctrl_if.sv
// Bus bundle between the instruction sequencer, the instruction memory and the datapath.
// The master modport is the sequencer; the slave modport is the memory/datapath side.
interface instr_seq_ctrl_if;
  logic       start;
  logic [3:0] OPcode;
  logic [5:0] label;
  logic       zero;
  logic       mem_ready;
  logic [7:0] PC;
  logic [3:0] ir_op;
  logic [5:0] ir_label;
  logic       alu_en;
  logic       alu_sub;
  logic       mem_req;
  logic       mem_we;
  logic       reg_we;
  logic       illegal;
  logic       mem_err;
  logic       halted;

  modport master (
    input  start, OPcode, label, zero, mem_ready,
    output PC, ir_op, ir_label, alu_en, alu_sub, mem_req, mem_we,
           reg_we, illegal, mem_err, halted
  );

  modport slave (
    output start, OPcode, label, zero, mem_ready,
    input  PC, ir_op, ir_label, alu_en, alu_sub, mem_req, mem_we,
           reg_we, illegal, mem_err, halted
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multicycle fetch/decode/execute sequencer owning the 6-bit PC of a 64-entry instruction memory.
// Optional feature: define MEM_TIMEOUT_EN to bound MEMWAIT to MEM_TIMEOUT cycles and flag mem_err.
module instr_seq_ctrl #(
  parameter logic [5:0] RESET_PC = 6'd0
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned MEM_TIMEOUT = 32'd15
`endif
) (
  input  logic              clock,
  input  logic              reset,
  instr_seq_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_BEQZ  = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_LOAD, OP_STORE,
      OP_JMP, OP_BEQZ, OP_HALT: is_legal = 1'b1;
      default:                  is_legal = 1'b0;
    endcase
  endfunction

  state_t     state_r, state_nxt_s;
  logic [5:0] pc_r, pc_nxt_s;
  logic [3:0] ir_op_r;
  logic [5:0] ir_label_r;
  logic       alu_en_r, alu_sub_r, mem_req_r, mem_we_r, reg_we_r, illegal_r, halted_r;
  logic       mem_op_s;
  logic       alu_en_nxt_s, alu_sub_nxt_s, mem_req_nxt_s, mem_we_nxt_s;
  logic       reg_we_nxt_s, illegal_nxt_s, halted_nxt_s;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 32'd1);
  logic [3:0] tmo_cnt_r;
  logic       err_set_s, err_clr_s, mem_err_r;
`endif

  // Next-state and next-PC decode
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
`ifdef MEM_TIMEOUT_EN
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
`endif
    case (state_r)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_nxt_s = S_FETCH;
          pc_nxt_s    = RESET_PC;
`ifdef MEM_TIMEOUT_EN
          err_clr_s   = 1'b1;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_FETCH:  state_nxt_s = S_DECODE;
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC: begin
        case (ir_op_r)
          OP_ADD, OP_SUB: state_nxt_s = S_WB;
          OP_LOAD, OP_STORE: begin
            if (bus.mem_ready) begin
              if (ir_op_r == OP_LOAD) begin
                state_nxt_s = S_WB;
              end else begin
                pc_nxt_s    = pc_r + 6'd1;
                state_nxt_s = S_FETCH;
              end
            end else begin
              state_nxt_s = S_MEMWAIT;
            end
          end
          OP_JMP: begin
            pc_nxt_s    = ir_label_r;
            state_nxt_s = S_FETCH;
          end
          OP_BEQZ: begin
            if (bus.zero) begin
              pc_nxt_s = ir_label_r;
            end else begin
              pc_nxt_s = pc_r + 6'd1;
            end
            state_nxt_s = S_FETCH;
          end
          OP_HALT: state_nxt_s = S_HALT;
          default: begin
            // NOP and undefined opcodes both just step the PC
            pc_nxt_s    = pc_r + 6'd1;
            state_nxt_s = S_FETCH;
          end
        endcase
      end
      S_MEMWAIT: begin
        if (bus.mem_ready) begin
          if (ir_op_r == OP_LOAD) begin
            state_nxt_s = S_WB;
          end else begin
            pc_nxt_s    = pc_r + 6'd1;
            state_nxt_s = S_FETCH;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = S_HALT;
          err_set_s   = 1'b1;
`endif
        end else begin
          state_nxt_s = S_MEMWAIT;
        end
      end
      S_WB: begin
        pc_nxt_s    = pc_r + 6'd1;
        state_nxt_s = S_FETCH;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they come straight out of flops
  assign mem_op_s      = (ir_op_r == OP_LOAD) || (ir_op_r == OP_STORE);
  assign alu_en_nxt_s  = (state_nxt_s == S_EXEC) && ((ir_op_r == OP_ADD) || (ir_op_r == OP_SUB));
  assign alu_sub_nxt_s = alu_en_nxt_s && (ir_op_r == OP_SUB);
  assign mem_req_nxt_s = ((state_nxt_s == S_EXEC) && mem_op_s) || (state_nxt_s == S_MEMWAIT);
  assign mem_we_nxt_s  = mem_req_nxt_s && (ir_op_r == OP_STORE);
  assign reg_we_nxt_s  = (state_nxt_s == S_WB);
  assign illegal_nxt_s = (state_r == S_FETCH) && !is_legal(bus.OPcode);
  assign halted_nxt_s  = (state_nxt_s == S_HALT);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, instruction register and registered strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      ir_op_r    <= 4'd0;
      ir_label_r <= 6'd0;
      alu_en_r   <= 1'b0;
      alu_sub_r  <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      reg_we_r   <= 1'b0;
      illegal_r  <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      pc_r <= pc_nxt_s;
      if (state_r == S_FETCH) begin
        ir_op_r    <= bus.OPcode;
        ir_label_r <= bus.label;
      end
      alu_en_r  <= alu_en_nxt_s;
      alu_sub_r <= alu_sub_nxt_s;
      mem_req_r <= mem_req_nxt_s;
      mem_we_r  <= mem_we_nxt_s;
      reg_we_r  <= reg_we_nxt_s;
      illegal_r <= illegal_nxt_s;
      halted_r  <= halted_nxt_s;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // MEMWAIT cycle counter and sticky timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= 4'd0;
      mem_err_r <= 1'b0;
    end else begin
      if (state_r == S_MEMWAIT) begin
        tmo_cnt_r <= tmo_cnt_r + 4'd1;
      end else begin
        tmo_cnt_r <= 4'd0;
      end
      if (err_clr_s) begin
        mem_err_r <= 1'b0;
      end else if (err_set_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end
  assign bus.mem_err = mem_err_r;
`else
  assign bus.mem_err = 1'b0;
`endif

  assign bus.PC       = {2'b00, pc_r};
  assign bus.ir_op    = ir_op_r;
  assign bus.ir_label = ir_label_r;
  assign bus.alu_en   = alu_en_r;
  assign bus.alu_sub  = alu_sub_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.reg_we   = reg_we_r;
  assign bus.illegal  = illegal_r;
  assign bus.halted   = halted_r;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: directed programs push expected events; a negedge monitor
// turns DUT outputs into events (kind, cycle since start, value) and compares them in order.
module tb_instr_seq_ctrl;

  localparam int K_ILL  = 1;
  localparam int K_ALU  = 2;
  localparam int K_MEM  = 3;
  localparam int K_REG  = 4;
  localparam int K_PC   = 5;
  localparam int K_HALT = 6;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_seq_ctrl_if bus();
  instr_seq_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  logic [3:0] im_op  [64];
  logic [5:0] im_lbl [64];
  assign bus.OPcode = im_op[bus.PC[5:0]];
  assign bus.label  = im_lbl[bus.PC[5:0]];
  assign bus.zero   = (bus.PC == 8'd41);

  ev_t expq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  load_delay = 4;
  int  rsp_cnt = 0;
  int  req_len = 0;
  int  req_we = 0;
  int  req_chg = 0;
  logic [7:0] prev_pc = 8'd0;
  logic       prev_halt = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_ILL:   return "illegal";
      K_ALU:   return "alu_en";
      K_MEM:   return "mem_req";
      K_REG:   return "reg_we";
      K_PC:    return "pc_change";
      K_HALT:  return "halted";
      default: return "unknown";
    endcase
  endfunction

  task automatic exp_ev(input int k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    expq.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got cyc %0d val %0d, want no event", kname(k), cyc, v);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        miscompares++;
        $display("FAIL ev_%s: got %s cyc %0d val %0d, want %s cyc %0d val %0d",
                 kname(e.kind), kname(k), cyc, v, kname(e.kind), e.cyc, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic chk_empty(input string name);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d events still pending, want 0", name, expq.size());
      expq.delete();
    end
  endtask

  // Memory responder: stores complete at once, loads after load_delay unready cycles.
  // A stray mem_ready while no request is pending (at PC 61) must be ignored.
  always @(negedge clock) begin
    if (bus.mem_req) begin
      rsp_cnt++;
      bus.mem_ready = (rsp_cnt > (bus.mem_we ? 0 : load_delay));
    end else begin
      rsp_cnt = 0;
      bus.mem_ready = (bus.PC == 8'd61);
    end
  end

  // Monitor: converts output activity into ordered events
  always @(negedge clock) begin
    if (bus.start) cyc = 0;
    else           cyc = cyc + 1;
    if (bus.illegal) observe(K_ILL, int'(bus.ir_op) * 64 + int'(bus.ir_label));
    if (bus.alu_en)  observe(K_ALU, int'(bus.alu_sub));
    if (bus.mem_req) begin
      if (req_len == 0) req_we = int'(bus.mem_we);
      else if (int'(bus.mem_we) != req_we) req_chg = 1;
      req_len++;
    end else if (req_len != 0) begin
      observe(K_MEM, req_len * 4 + req_we * 2 + req_chg);
      req_len = 0;
      req_chg = 0;
    end
    if (bus.reg_we) observe(K_REG, int'(bus.PC));
    if (bus.PC != prev_pc) observe(K_PC, int'(bus.PC));
    prev_pc = bus.PC;
    if (bus.halted && !prev_halt) observe(K_HALT, int'(bus.PC));
    prev_halt = bus.halted;
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      im_op[i]  = 4'b0000;
      im_lbl[i] = 6'd0;
    end
  endtask

  task automatic start_pulse();
    @(posedge clock); #1 bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.halted) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_halt_timeout: got halted=0 after 300 cycles, want 1", name);
    end
    repeat (2) @(negedge clock);
    chk_empty({name, "_pending"});
  endtask

  task automatic load_prog_a();
    clear_mem();
    im_op[0] = 4'b0000;
    im_op[1] = 4'b0001;
    im_op[2] = 4'b1111;
  endtask

  task automatic expect_prog_a();
    exp_ev(K_PC, 4, 1);
    exp_ev(K_ALU, 6, 0);
    exp_ev(K_REG, 7, 1);
    exp_ev(K_PC, 8, 2);
    exp_ev(K_HALT, 11, 2);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    clear_mem();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", int'(bus.PC), 0);
    chk("rst_ir_op", int'(bus.ir_op), 0);
    chk("rst_ir_label", int'(bus.ir_label), 0);
    chk("rst_strobes", int'({bus.alu_en, bus.alu_sub, bus.mem_req, bus.mem_we, bus.reg_we}), 0);
    chk("rst_flags", int'({bus.illegal, bus.mem_err, bus.halted}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Program A: NOP, ADD, HALT
    load_prog_a();
    expect_prog_a();
    start_pulse();
    wait_halt("prog_a");

    // Program B: JMP 5; 5: JMP 40; 40: BEQZ (zero=0); 41: BEQZ 3 (zero=1); 3: HALT
    clear_mem();
    im_op[0]  = 4'b0101; im_lbl[0]  = 6'd5;
    im_op[5]  = 4'b0101; im_lbl[5]  = 6'd40;
    im_op[40] = 4'b0110; im_lbl[40] = 6'd50;
    im_op[41] = 4'b0110; im_lbl[41] = 6'd3;
    im_op[3]  = 4'b1111;
    exp_ev(K_PC, 1, 0);
    exp_ev(K_PC, 4, 5);
    exp_ev(K_PC, 7, 40);
    exp_ev(K_PC, 10, 41);
    exp_ev(K_PC, 13, 3);
    exp_ev(K_HALT, 16, 3);
    start_pulse();
    wait_halt("prog_b");

    // Program C: JMP 60; LOAD (4 wait cycles); illegal 1010; NOP; STORE at 63 wrapping to HALT at 0
    clear_mem();
    load_delay = 4;
    im_op[0]  = 4'b0101; im_lbl[0]  = 6'd60;
    im_op[60] = 4'b0011;
    im_op[61] = 4'b1010; im_lbl[61] = 6'd21;
    im_op[62] = 4'b0000;
    im_op[63] = 4'b0100;
    exp_ev(K_PC, 1, 0);
    exp_ev(K_PC, 4, 60);
    exp_ev(K_MEM, 11, 5 * 4 + 0 + 0);
    exp_ev(K_REG, 11, 60);
    exp_ev(K_PC, 12, 61);
    exp_ev(K_ILL, 13, 10 * 64 + 21);
    exp_ev(K_PC, 15, 62);
    exp_ev(K_PC, 18, 63);
    exp_ev(K_MEM, 21, 1 * 4 + 2 + 0);
    exp_ev(K_PC, 21, 0);
    exp_ev(K_HALT, 24, 0);
    start_pulse();
    repeat (5) @(posedge clock);
    im_op[0] = 4'b1111;
    wait_halt("prog_c");
    chk("prog_c_mem_err", int'(bus.mem_err), 0);

    // Program D: reset while a LOAD sits in MEMWAIT
    clear_mem();
    load_delay = 1000;
    im_op[0] = 4'b0011;
    exp_ev(K_MEM, 6, 3 * 4);
    start_pulse();
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_req_async", int'(bus.mem_req), 0);
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_pc", int'(bus.PC), 0);
    chk("midrst_ir_op", int'(bus.ir_op), 0);
    chk("midrst_strobes", int'({bus.alu_en, bus.mem_req, bus.mem_we, bus.reg_we, bus.halted}), 0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk_empty("midrst_pending");
    chk("midrst_idle_pc", int'(bus.PC), 0);

    // Restart after reset: program A again
    load_prog_a();
    expect_prog_a();
    start_pulse();
    wait_halt("prog_a_again");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
# instr_seq_ctrl

Multicycle fetch/decode/execute sequencer for the 64-entry instruction memory. It owns the program counter, latches the instruction memory's opcode/label outputs into an instruction register and decodes them. It then drives the ALU, register-file and data-memory strobes of the datapath. It sits between the instruction memory and the datapath and is the only block that changes the PC.

## Interface
- RESET_PC, 6'd0, PC value loaded on reset and on `start` from IDLE.
- MEM_TIMEOUT, 15, maximum wait in MEMWAIT, in cycles. Used only with MEM_TIMEOUT_EN; range 1..15.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins fetching at RESET_PC.
- OPcode  in  4  opcode from instruction memory; combinational on PC.
- label  in  6  label/immediate from instruction memory.
- zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  data-memory completion; counts only while mem_req=1.
- PC  out  8  instruction address. Bits [7:6] are always 0.
- ir_op  out  4  latched opcode.
- ir_label  out  6  latched label.
- alu_en  out  1  ALU operate strobe.
- alu_sub  out  1  1 = subtract, 0 = add; valid with alu_en.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store; valid with mem_req.
- reg_we  out  1  register-file write pulse.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- mem_err  out  1  sticky memory-timeout flag; cleared by reset or start.
- halted  out  1  high in HALT.

## Operation
- Opcode map:
  - 0000 NOP
  - 0001 ADD
  - 0010 SUB
  - 0011 LOAD
  - 0100 STORE
  - 0101 JMP label
  - 0110 BEQZ label
  - 1111 HALT
  - All others are illegal and execute as NOP, pulsing `illegal` in DECODE.
- States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, WB, HALT.
- IDLE: outputs inactive. `start` sets PC=RESET_PC and goes to FETCH.
- FETCH: load ir_op<=OPcode and ir_label<=label, then go to DECODE.
- DECODE: pulse `illegal` if needed, then go to EXEC.
- EXEC, per instruction:
  - ADD/SUB: alu_en=1, alu_sub=(op==SUB), go to WB.
  - LOAD/STORE: mem_req=1, mem_we=(op==STORE). If mem_ready=1 this cycle, the transfer completes: LOAD goes to WB, STORE does PC+1 and goes to FETCH. Otherwise go to MEMWAIT.
  - JMP: PC<={2'b00,ir_label}, go to FETCH.
  - BEQZ: if zero=1 then PC<={2'b00,ir_label}, else PC+1; go to FETCH.
  - HALT: go to HALT with PC unchanged.
  - NOP/illegal: PC+1, go to FETCH.
- MEMWAIT: hold mem_req and mem_we. On mem_ready, same exit as the EXEC completion case.
- WB: reg_we=1 for one cycle, PC+1, go to FETCH.
- HALT: halted=1, all strobes 0. `start` restarts at RESET_PC.
- PC increment is modulo 64: PC 63 -> 0.
- `start` outside IDLE/HALT is ignored.

## Timing
- Reset (async): state=IDLE, PC=RESET_PC, ir_op=0, ir_label=0, all strobes 0, illegal=0, mem_err=0, halted=0.
- Reset asserted mid-instruction aborts it immediately; no strobe is completed afterwards.
- Strobes are Moore outputs decoded from state and ir_op, so they are glitch-free after the clock edge.
- Latency per instruction, counted FETCH to next FETCH:
  - NOP, JMP, BEQZ, illegal: 3 cycles.
  - ADD, SUB: 4 cycles.
  - STORE: 3+w cycles; LOAD: 4+w cycles. w = number of cycles with mem_req=1 and mem_ready=0.
- mem_ready while mem_req=0 is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A 4-bit counter clears on entering MEMWAIT and increments each MEMWAIT cycle.
  - When it reaches MEM_TIMEOUT with no mem_ready, mem_req drops, mem_err is set, and the FSM goes to HALT.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- MEM_TIMEOUT_EN undefined: MEMWAIT waits indefinitely; mem_err is tied to 0.

## Test plan
- Reset then start with program {NOP, ADD, HALT}:
  - PC goes 0,1,2.
  - alu_en=1, alu_sub=0 in the ADD EXEC cycle; reg_we pulses exactly once.
  - halted=1 after 3+4+3 cycles; PC stays at 2.
- JMP at address 5 with label 6'd40 -> PC=40 on the cycle after EXEC. Then BEQZ with zero=0 gives PC=41; with zero=1 and label=3 gives PC=3.
- LOAD with mem_ready delayed 4 cycles:
  - mem_req and mem_we=0 are held for 5 cycles, then reg_we pulses once.
  - Total latency is 8 cycles.
- STORE at PC=63 with mem_ready=1 in EXEC: mem_we=1 for 1 cycle, no reg_we, next PC=0 (wrap).
- Opcode 1010: `illegal` pulses once in DECODE and PC advances by 1. Reset asserted during a LOAD's MEMWAIT drops mem_req asynchronously and gives state IDLE, PC=0.
- With MEM_TIMEOUT_EN and MEM_TIMEOUT=15, a LOAD with mem_ready never asserted:
  - mem_err=1 and halted=1 after 15 MEMWAIT cycles; reg_we never pulses.
  - A following start clears mem_err.
